// File: rtl/s2p_row_arbiter.sv
// Round-robin sequencer that shares one serial_to_parallel pairer among NUM_REQ row streams.
// Every granted row starts with a pairer clear, so no {prev, cur} pair spans two rows or sources.
module s2p_row_arbiter #(
  parameter int DATA_W  = 32,
  parameter int NUM_REQ = 4,
  parameter int ROW_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          s2p_data,
  output logic                       s2p_valid,
  output logic                       s2p_clear,
  input  logic                       s2p_o_valid,
  output logic [$clog2(NUM_REQ)-1:0] pair_src,
  output logic [$clog2(ROW_LEN)-1:0] pair_idx,
  output logic                       row_done,
  output logic                       busy,
  output logic                       pair_err
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ROW_LEN);
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(ROW_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_M1 = CNT_W'(ROW_LEN - 2);
  localparam logic [SRC_W-1:0] TOP_SRC = SRC_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [SRC_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   word_cnt;
  logic [CNT_W-1:0]   pair_cnt;

  // First requesting index at or above ptr, wrapping; ptr when nobody requests.
  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                               input logic [SRC_W-1:0]   ptr);
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = SRC_W'((int'(ptr) + k) % NUM_REQ);
      if (v[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] src);
    return (src == TOP_SRC) ? '0 : src + 1'b1;
  endfunction

  logic cnt_phase;
  logic hs;
  logic pair_inc;
  logic err_hit;
  logic drain_done;

  assign cnt_phase  = (state == S_STREAM) || (state == S_DRAIN);
  assign hs         = (state == S_STREAM) && req_valid[pair_src];
  assign pair_inc   = cnt_phase && s2p_o_valid && (pair_cnt != LAST);
  assign err_hit    = s2p_o_valid && (!cnt_phase || (pair_cnt == LAST));
  // Leave DRAIN in the same cycle the final pair lands, keeping the row at ROW_LEN+4 cycles.
  assign drain_done = (pair_cnt == LAST) || (s2p_o_valid && (pair_cnt == LAST_M1));

  always_comb begin
    req_ready = '0;
    s2p_valid = 1'b0;
    s2p_data  = '0;
    if (state == S_STREAM) begin
      req_ready[pair_src] = 1'b1;
      s2p_valid           = req_valid[pair_src];
      s2p_data            = req_data[pair_src*DATA_W +: DATA_W];
    end
  end

  assign s2p_clear = (state == S_CLEAR);
  assign row_done  = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign pair_idx  = pair_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      pair_src <= '0;
      word_cnt <= '0;
      pair_cnt <= '0;
      pair_err <= 1'b0;
    end else begin
      if (err_hit)  pair_err <= 1'b1;
      if (pair_inc) pair_cnt <= pair_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (|req_valid) begin
            pair_src <= rr_pick(req_valid, rr_ptr);
            state    <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          word_cnt <= '0;
          pair_cnt <= '0;
          state    <= S_STREAM;
        end
        S_STREAM: begin
          if (hs) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (drain_done) state <= S_DONE;
        end
        S_DONE: begin
          rr_ptr <= next_src(pair_src);
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s2p_row_arbiter.sv
// Bench for s2p_row_arbiter: requester and pairer models drive the DUT, a round-robin
// reference model fills a scoreboard, and a monitor checks pairs and row completions.
module tb_s2p_row_arbiter;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int RL = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     s2p_data;
  logic              s2p_valid;
  logic              s2p_clear;
  logic              s2p_o_valid = 1'b0;
  logic [1:0]        pair_src;
  logic [1:0]        pair_idx;
  logic              row_done;
  logic              busy;
  logic              pair_err;

  s2p_row_arbiter #(.DATA_W(DW), .NUM_REQ(NR), .ROW_LEN(RL)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .s2p_data(s2p_data), .s2p_valid(s2p_valid),
    .s2p_clear(s2p_clear), .s2p_o_valid(s2p_o_valid), .pair_src(pair_src),
    .pair_idx(pair_idx), .row_done(row_done), .busy(busy), .pair_err(pair_err)
  );

  always #5 clk = ~clk;

  typedef struct { int src; int idx; logic [63:0] data; } pair_t;
  typedef struct { int src; int extra; bit b2b; } row_t;

  pair_t         exp_pair_q[$];
  row_t          exp_row_q[$];
  logic [DW-1:0] req_q[NR][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_ptr = 0;

  // Stimulus knobs
  bit gaps_on = 0;
  int stall_src = -1;
  int stall_left = 0;
  bit inj_one = 0;
  bit inj_stream = 0;
  bit inj_now = 0;
  bit skip_pairs = 0;

  // Pairer model state
  bit            pend_v = 0;
  logic [63:0]   pend_d = '0;
  logic [63:0]   pair_data = '0;
  bit            have_prev = 0;
  logic [DW-1:0] prev_w = '0;
  logic [NR-1:0] hs_mask = '0;
  bit            drv_v;
  logic [DW-1:0] drv_dummy;

  // Monitor state
  int clr_cyc = 0;
  int last_done = 0;
  int row_pairs = 0;
  bit first_pend = 0;
  bit busy_chk = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (req_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: queue the words, then derive grant order from rows pending per requester.
  task automatic load_rows(input int n0, input int n1, input int n2, input int n3, input bit b2b);
    int left[NR];
    int row_no[NR];
    int j;
    bit first;
    pair_t p;
    row_t r;
    left[0] = n0; left[1] = n1; left[2] = n2; left[3] = n3;
    for (int i = 0; i < NR; i++) begin
      row_no[i] = 0;
      for (int w = 0; w < left[i] * RL; w++) req_q[i].push_back($urandom);
    end
    first = 1'b1;
    while (left[0] + left[1] + left[2] + left[3] > 0) begin
      j = model_ptr;
      while (left[j] == 0) j = (j + 1) % NR;
      if (!skip_pairs) begin
        for (int k = 0; k < RL - 1; k++) begin
          p.src  = j;
          p.idx  = k;
          p.data = {req_q[j][row_no[j]*RL + k], req_q[j][row_no[j]*RL + k + 1]};
          exp_pair_q.push_back(p);
        end
      end
      r.src   = j;
      r.extra = gaps_on ? -1 : ((j == stall_src) ? stall_left : 0);
      r.b2b   = b2b && !first;
      exp_row_q.push_back(r);
      first = 1'b0;
      left[j]--;
      row_no[j]++;
      model_ptr = (j + 1) % NR;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(exp_row_q.size() == 0 && !busy && all_empty()) && n < budget);
    if (n >= budget) begin
      checks++; errors++;
      $display("FAIL wait_idle timeout rows_left=%0d busy=%0b", exp_row_q.size(), busy);
    end
  endtask

  task automatic flush();
    for (int i = 0; i < NR; i++) req_q[i].delete();
    exp_pair_q.delete();
    exp_row_q.delete();
    model_ptr = 0;
    busy_chk = 0;
    first_pend = 0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_s2p_data"}, s2p_data, 0);
    check({tag, "_s2p_valid"}, s2p_valid, 0);
    check({tag, "_s2p_clear"}, s2p_clear, 0);
    check({tag, "_pair_src"}, pair_src, 0);
    check({tag, "_pair_idx"}, pair_idx, 0);
    check({tag, "_row_done"}, row_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_pair_err"}, pair_err, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    flush();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Requesters and pairer model, driven on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      req_valid   = '0;
      s2p_o_valid = 1'b0;
      pend_v      = 1'b0;
      hs_mask     = '0;
      inj_now     = 1'b0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (hs_mask[i] && req_q[i].size() > 0) drv_dummy = req_q[i].pop_front();
      for (int i = 0; i < NR; i++) begin
        drv_v = (req_q[i].size() > 0);
        if (drv_v && req_ready[i]) begin
          if (gaps_on && $urandom_range(0, 3) == 0) drv_v = 1'b0;
          if (i == stall_src && stall_left > 0 && req_q[i].size() == RL - 2) begin
            drv_v = 1'b0;
            stall_left--;
          end
        end
        req_valid[i] = drv_v;
        req_data[i*DW +: DW] = drv_v ? req_q[i][0] : $urandom;
      end
      inj_now     = inj_one || (inj_stream && req_ready != '0);
      inj_one     = 1'b0;
      s2p_o_valid = pend_v | inj_now;
      pair_data   = pend_d;
      #1;
      hs_mask = req_valid & req_ready;
      pend_v  = 1'b0;
      if (s2p_clear) have_prev = 1'b0;
      else if (s2p_valid) begin
        if (have_prev) begin
          pend_v = 1'b1;
          pend_d = {prev_w, s2p_data};
        end
        prev_w    = s2p_data;
        have_prev = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a pair or completes a row.
  always @(negedge clk) begin
    pair_t e;
    row_t r;
    #2;
    if (!rst) begin
      if (busy_chk) begin
        check("busy_fall", busy, 0);
        busy_chk = 0;
      end
      check("ready_onehot", $countones(req_ready) <= 1, 1);
      if (s2p_clear) begin
        clr_cyc    = cyc;
        row_pairs  = 0;
        first_pend = 1;
        check("clear_no_valid", s2p_valid, 0);
      end
      if (first_pend && (req_valid & req_ready) != '0) begin
        first_pend = 0;
        if (!gaps_on) check("first_word_lat", cyc - clr_cyc, 1);
      end
      if (s2p_o_valid && !inj_now && !skip_pairs) begin
        row_pairs++;
        if (exp_pair_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pair src=%0d idx=%0d want=none", pair_src, pair_idx);
        end else begin
          e = exp_pair_q.pop_front();
          check("pair_src", pair_src, e.src);
          check("pair_idx", pair_idx, e.idx);
          check("pair_data", pair_data, e.data);
        end
      end
      if (row_done) begin
        if (exp_row_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_row_done src=%0d want=none", pair_src);
        end else begin
          r = exp_row_q.pop_front();
          check("row_src", pair_src, r.src);
          if (!skip_pairs) check("pairs_per_row", row_pairs, RL - 1);
          if (r.extra >= 0) check("row_time", cyc - clr_cyc, RL + 2 + r.extra);
          if (r.b2b) check("row_period", cyc - last_done, RL + 4);
          if (exp_row_q.size() == 0 && all_empty()) busy_chk = 1;
        end
        last_done = cyc;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;

    // Single requester, back-to-back words
    load_rows(1, 0, 0, 0, 0);
    wait_idle(200);

    // Requester 2 stalls three cycles mid-row while 1 and 3 wait
    stall_src = 2; stall_left = 3;
    load_rows(0, 1, 1, 1, 0);
    wait_idle(300);
    stall_src = -1;

    // Rows from sources 1 and 3 separated by a clear
    load_rows(0, 1, 0, 1, 0);
    wait_idle(200);

    // All four continuously valid: rotation and row period
    load_rows(2, 2, 2, 2, 1);
    wait_idle(400);
    check("err_clean_a", pair_err, 0);

    // Random row counts with random valid gaps
    gaps_on = 1;
    for (int t = 0; t < 4; t++) begin
      load_rows($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                $urandom_range(0, 2), 0);
      wait_idle(2000);
    end
    gaps_on = 0;
    check("err_clean_b", pair_err, 0);

    // Reset mid-row discards the partial row; arbitration restarts at requester 0
    load_rows(0, 1, 0, 0, 0);
    wait_idle(200);
    load_rows(0, 0, 1, 0, 0);
    for (int n = 0; n < 200 && req_q[2].size() > RL - 2; n++) begin
      @(posedge clk); #1;
    end
    check("midrow_words_left", req_q[2].size(), RL - 2);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    flush();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    load_rows(1, 0, 0, 1, 0);
    wait_idle(200);

    // Pair returned while idle sets a sticky error; rows still complete
    check("err_pre", pair_err, 0);
    inj_one = 1;
    repeat (3) @(posedge clk);
    #1;
    check("err_idle", pair_err, 1);
    load_rows(0, 0, 0, 1, 0);
    wait_idle(200);
    check("err_sticky", pair_err, 1);

    // Extra pairs beyond ROW_LEN-1 within a row
    do_reset();
    check("err_after_rst", pair_err, 0);
    skip_pairs = 1; inj_stream = 1;
    load_rows(0, 1, 0, 0, 0);
    wait_idle(200);
    inj_stream = 0; skip_pairs = 0;
    check("err_count", pair_err, 1);
    load_rows(0, 0, 1, 0, 0);
    wait_idle(200);
    check("err_sticky2", pair_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/s2p_row_arbiter.md
# s2p_row_arbiter

Round-robin arbiter and sequencer that shares one `serial_to_parallel` pairing unit between `NUM_REQ` row-stream requesters in the HOG feature path. It grants one requester at a time for a full row of `ROW_LEN` words and pulses the pairer's `clear` before each row, so that no `{prev, cur}` pair ever spans two rows or two sources. It counts the pairs the pairer returns, tags each pair with its source ID, and signals row completion.

## Interface
- `DATA_W`, 32, word width; equals the pairer's `DATA_WIDTH`.
- `NUM_REQ`, 4, number of requesters (2..16).
- `ROW_LEN`, 16, words per row (>= 2); the pairer returns `ROW_LEN-1` pairs per row.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester word valid.
- `req_data`  in  NUM_REQ*DATA_W  requester words; requester i uses bits `[i*DATA_W +: DATA_W]`.
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero.
- `s2p_data`  out  DATA_W  word to the pairer's `i_data`.
- `s2p_valid`  out  1  to the pairer's `i_valid`.
- `s2p_clear`  out  1  to the pairer's `clear`.
- `s2p_o_valid`  in  1  pairer's `o_valid`.
- `pair_src`  out  $clog2(NUM_REQ)  owner of the current row; valid while `busy`.
- `pair_idx`  out  $clog2(ROW_LEN)  index (0..ROW_LEN-2) of the pair on `s2p_o_valid`.
- `row_done`  out  1  one-cycle pulse when a row's last pair has been returned.
- `busy`  out  1  high in every state except IDLE.
- `pair_err`  out  1  sticky; cleared only by `rst`.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, DONE.
- IDLE: if any `req_valid` bit is set, grant the first set bit searching upward from `rr_ptr` with wrap. Register the grant into `pair_src`, then go to CLEAR. If no bit is set, stay in IDLE.
- CLEAR: `s2p_clear`=1 and `s2p_valid`=0 for exactly one cycle. Reset `word_cnt` and `pair_cnt` to 0, then go to STREAM.
- STREAM:
  - `req_ready[pair_src]`=1; all other `req_ready` bits are 0.
  - `s2p_data` = the `req_data` slice of `pair_src`, combinational.
  - `s2p_valid` = `req_valid[pair_src]`.
  - A handshake (valid & ready) increments `word_cnt`.
  - On the `ROW_LEN`-th handshake, go to DRAIN.
  - Gaps in `req_valid` only stall the row; other requesters wait.
- DRAIN: `req_ready`=0 and `s2p_valid`=0. Wait until `pair_cnt` == `ROW_LEN-1`, then go to DONE.
- DONE: `row_done`=1 for one cycle. Set `rr_ptr` = `pair_src`+1, wrapping modulo `NUM_REQ`. Go to IDLE.
- Pair counting:
  - In STREAM and DRAIN, each `s2p_o_valid` drives `pair_idx` = `pair_cnt`, then increments `pair_cnt`.
  - `pair_cnt` saturates at `ROW_LEN-1`.
- `pair_err` is set by any of:
  - `s2p_o_valid` in IDLE, CLEAR or DONE;
  - `s2p_o_valid` when `pair_cnt` == `ROW_LEN-1`.
- `pair_err` does not alter sequencing.

## Timing
- Reset values:
  - outputs: `req_ready`=0, `s2p_data`=0, `s2p_valid`=0, `s2p_clear`=0, `pair_src`=0, `pair_idx`=0, `row_done`=0, `busy`=0, `pair_err`=0;
  - internal: state = IDLE, `rr_ptr`=0, `word_cnt`=0, `pair_cnt`=0.
- Grant latency: `req_valid` seen in IDLE at cycle t gives CLEAR at t+1 and first `req_ready` at t+2.
- The pairer returns pair k one cycle after word k+1 is accepted. The controller does not depend on this latency; it only counts pairs.
- Minimum row time with no gaps: 1 (IDLE) + 1 (CLEAR) + `ROW_LEN` + 1 (DRAIN) + 1 (DONE) = `ROW_LEN`+4 cycles.
- Arbitration happens only in IDLE. The grant never changes mid-row, and new requests during a row are held until DONE→IDLE.
- Reset mid-row: all outputs and state return to reset values immediately. No `row_done` is issued, and the partial row is discarded. The next row begins with CLEAR, so no stale pair leaks out.
- `ROW_LEN`=2: exactly one pair; DRAIN exits on the first `s2p_o_valid`.

## Test plan
- Single requester 0, `ROW_LEN`=4, words A,B,C,D back-to-back:
  - `s2p_clear` pulses one cycle before A;
  - pairs {A,B},{B,C},{C,D} arrive with `pair_idx` 0,1,2 and `pair_src`=0;
  - `row_done` pulses once;
  - `busy` falls one cycle after `row_done`.
- All 4 requesters valid continuously: grant order is 0,1,2,3,0,…; each row is `ROW_LEN`+4 cycles; `req_ready` is never more than one-hot.
- Requester 2 drops `req_valid` for 3 cycles mid-row while 1 and 3 request: the row stretches by 3 cycles, no other grant occurs, and the pairs stay correct.
- First-word check: `clear` is issued between rows from sources 1 and 3. No pair combines the last word of row 1 with the first word of row 3; exactly `ROW_LEN-1` pairs arrive per row.
- `rst` asserted after 5 of 16 words: all outputs go to 0 asynchronously and `row_done` never pulses. After release, a new request is granted starting from requester 0.
- Forced `s2p_o_valid` in IDLE, and a forced extra pair after `ROW_LEN-1` pairs: `pair_err` goes to 1 and stays 1 until `rst`, and the next row still completes normally.
